// File: rtl/rd_capture_ctrl.sv
// Read-side responder: wait-state generation, ds-strobed capture into a FIFO, address advance.
// Optional RD_CAPTURE_PARITY_EN adds mem_rpar/m_perr with per-entry parity-error storage.
module rd_capture_ctrl #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rd,
   input  logic                      ds,
   output logic                      ws,
   input  logic [CW-1:0]             wait_cfg,
   input  logic                      addr_clr,
   output logic [AW-1:0]             mem_addr,
   input  logic [DW-1:0]             mem_rdata,
   output logic [DW-1:0]             m_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      ovf,
`ifdef RD_CAPTURE_PARITY_EN
   output logic                      proto_err,
   input  logic                      mem_rpar,
   output logic                      m_perr
`else
   output logic                      proto_err
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);
`ifdef RD_CAPTURE_PARITY_EN
   localparam int unsigned EW = DW + 1;
`else
   localparam int unsigned EW = DW;
`endif

   logic            rd_q;
   logic [CW-1:0]   wcnt;
   logic            armed;
   logic [PW-1:0]   wptr, rptr, rptr_nx;
   logic [PW:0]     count, count_nx;
   logic [EW-1:0]   fifo_mem [DEPTH];
   logic [EW-1:0]   wdata, head_q, head_nx;
   logic            rise, full, pop, push;

`ifdef RD_CAPTURE_PARITY_EN
   assign wdata  = {^mem_rdata ^ mem_rpar, mem_rdata};
   assign m_perr = head_q[DW];
`else
   assign wdata  = mem_rdata;
`endif

   assign rise    = rd & ~rd_q;
   assign full    = (count == FULL_LVL);
   assign m_valid = (count != '0);
   assign pop     = m_valid & m_ready;
   assign push    = ds & armed & (~full | pop);
   assign ws      = (wcnt != '0) | full;
   assign level   = count;
   assign m_data  = head_q[DW-1:0];

   // Head is registered so m_data holds its last word while empty; a word
   // landing at the new read pointer in this cycle bypasses the array.
   always_comb begin
      rptr_nx = pop ? rptr + 1'b1 : rptr;
      case ({push, pop})
         2'b10:   count_nx = count + 1'b1;
         2'b01:   count_nx = count - 1'b1;
         default: count_nx = count;
      endcase
      head_nx = head_q;
      if (push && (rptr_nx == wptr))
         head_nx = wdata;
      else if (count_nx != '0)
         head_nx = fifo_mem[rptr_nx];
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q      <= 1'b0;
         wcnt      <= '0;
         armed     <= 1'b0;
         mem_addr  <= '0;
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         head_q    <= '0;
         ovf       <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         rd_q <= rd;
         if (rise)
            wcnt <= wait_cfg;
         else if (rd && (wcnt != '0))
            wcnt <= wcnt - 1'b1;
         // A new rise re-arms even if the previous read completes in the same cycle.
         if (rise)
            armed <= 1'b1;
         else if (push)
            armed <= 1'b0;
         if (addr_clr)
            mem_addr <= '0;
         else if (push)
            mem_addr <= mem_addr + 1'b1;
         if (push)
            wptr <= wptr + 1'b1;
         rptr   <= rptr_nx;
         count  <= count_nx;
         head_q <= head_nx;
         if (ds && armed && full && !pop)
            ovf <= 1'b1;
         if (ds && !armed)
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rd_capture_ctrl.sv
// Scoreboard bench for rd_capture_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_rd_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd = 1'b0, ds = 1'b0, addr_clr = 1'b0, m_ready = 1'b1, mem_rpar = 1'b0;
   logic [3:0]  wait_cfg = '0;
   logic [15:0] mem_rdata = '0;
   logic        ws, m_valid, ovf, proto_err;
   logic [7:0]  mem_addr;
   logic [15:0] m_data;
   logic [2:0]  level;
`ifdef RD_CAPTURE_PARITY_EN
   logic        m_perr;
`endif

   rd_capture_ctrl #(.AW(8), .DW(16), .DEPTH(4), .CW(4)) dut (
      .clk(clk), .rst_n(rst_n), .rd(rd), .ds(ds), .ws(ws), .wait_cfg(wait_cfg),
      .addr_clr(addr_clr), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
      .ovf(ovf),
`ifdef RD_CAPTURE_PARITY_EN
      .proto_err(proto_err), .mem_rpar(mem_rpar), .m_perr(m_perr)
`else
      .proto_err(proto_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [15:0] d; logic p; } ent_t;
   ent_t sb[$];

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   // Reference model state
   bit          m_rdq, m_armed, m_ovf, m_proto;
   int          m_wait, m_count, m_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: occupancy count, address, wait budget and flags from the read rules.
   initial forever begin
      bit rise, pop, push;
      @(posedge clk);
      if (!rst_n) begin
         m_rdq = 0; m_armed = 0; m_ovf = 0; m_proto = 0;
         m_wait = 0; m_count = 0; m_addr = 0;
         sb.delete();
      end else begin
         rise = rd && !m_rdq;
         pop  = (m_count != 0) && m_ready;
         push = 0;
         if (ds) begin
            if (!m_armed) m_proto = 1;
            else if (m_count < 4 || pop) push = 1;
            else m_ovf = 1;
         end
         if (push) begin
            sb.push_back('{d: mem_rdata, p: (^mem_rdata) ^ mem_rpar});
            m_armed = 0;
            m_addr = (m_addr + 1) % 256;
         end
         if (addr_clr) m_addr = 0;
         if (rise) begin
            m_wait = int'(wait_cfg);
            m_armed = 1;
         end else if (rd && m_wait > 0) begin
            m_wait--;
         end
         m_count = m_count + int'(push) - int'(pop);
         m_rdq = rd;
      end
   end

   // Monitor: compares status every cycle, and the head word whenever m_valid is presented.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("ws", ws, (m_wait != 0) || (m_count == 4));
         check("level", level, m_count);
         check("mem_addr", mem_addr, m_addr);
         check("ovf", ovf, m_ovf);
         check("proto_err", proto_err, m_proto);
         check("m_valid", m_valid, sb.size() != 0);
         if (m_valid && sb.size() != 0) begin
            check("m_data", m_data, sb[0].d);
`ifdef RD_CAPTURE_PARITY_EN
            check("m_perr", m_perr, sb[0].p);
`endif
            if (m_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0; rd = 0; ds = 0; addr_clr = 0;
      cyc(2);
      rst_n = 1;
   endtask

   task automatic do_read(input logic [3:0] wc, input logic [15:0] d, input int hold, input logic clr);
      rd = 1; wait_cfg = wc;
      cyc(hold);
      ds = 1; mem_rdata = d; mem_rpar = 1'($urandom_range(0, 1)); addr_clr = clr;
      cyc(1);
      ds = 0; rd = 0; addr_clr = 0;
      cyc(1);
   endtask

   initial begin
      #1;
      do_reset();
      chk_en = 1;
      cyc(10);
      check("idle_ws", ws, 0);
      check("idle_level", level, 0);

      m_ready = 1;
      do_read(4'd3, 16'hA5A5, 5, 0);
      check("first_addr", mem_addr, 1);

      do_reset();
      m_ready = 0;
      for (int i = 0; i < 4; i++) do_read(4'd0, 16'h1000 + 16'(i), 1, 0);
      check("full_level", level, 4);
      check("full_ws", ws, 1);
      do_read(4'd0, 16'hDEAD, 1, 0);
      check("ovf_set", ovf, 1);
      check("ovf_addr_hold", mem_addr, 4);
      m_ready = 1;
      cyc(1);
      m_ready = 0;
      check("ws_after_pop", ws, 0);
      check("level_after_pop", level, 3);
      m_ready = 1;
      cyc(5);

      do_reset();
      ds = 1; mem_rdata = 16'h5555;
      cyc(1);
      ds = 0;
      cyc(1);
      check("proto_err", proto_err, 1);
      check("proto_level", level, 0);
      check("proto_addr", mem_addr, 0);

      do_reset();
      m_ready = 1;
      for (int i = 0; i < 255; i++) do_read(4'(i % 3), 16'($urandom), 1, 0);
      check("addr_ff", mem_addr, 8'hFF);
      do_read(4'd0, 16'h0F0F, 1, 0);
      check("addr_wrap", mem_addr, 0);
      do_read(4'd1, 16'h1234, 2, 0);
      do_read(4'd0, 16'h4321, 1, 1);
      check("addr_clr_prio", mem_addr, 0);

      do_reset();
      m_ready = 0;
      for (int i = 0; i < 3; i++) do_read(4'd0, 16'hB000 + 16'(i), 1, 0);
      rd = 1; wait_cfg = 4'd5;
      cyc(4);
      rst_n = 0;
      cyc(1);
      check("rst_ws", ws, 0);
      check("rst_level", level, 0);
      check("rst_valid", m_valid, 0);
      rst_n = 1; rd = 0;
      cyc(2);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) rd = ~rd;
         ds        = ($urandom_range(0, 5) == 0);
         m_ready   = 1'($urandom_range(0, 1));
         addr_clr  = ($urandom_range(0, 39) == 0);
         wait_cfg  = 4'($urandom_range(0, 4));
         mem_rdata = 16'($urandom);
         mem_rpar  = 1'($urandom_range(0, 1));
         rst_n     = ($urandom_range(0, 399) != 0);
         cyc(1);
      end
      rst_n = 1; rd = 0; ds = 0; addr_clr = 0;
      cyc(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
